// File: rtl/preg_free_list.sv
// R10K-style physical register free list: speculative/architectural free bitmaps, ALLOC_W-wide
// lowest-index allocator, retire release, and mispredict restore. Optional macro: PREG_FREE_LIST_CHECK_EN.
module preg_free_list #(
  parameter int NUM_PREGS  = 64,
  parameter int PREG_IDX_W = 6,
  parameter int NUM_AREGS  = 32,
  parameter int ALLOC_W    = 2,
  parameter int RET_W      = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ALLOC_W-1:0]            alloc_req,
  output logic [ALLOC_W-1:0]            alloc_gnt,
  output logic [ALLOC_W*PREG_IDX_W-1:0] alloc_idx,
  input  logic [RET_W-1:0]              ret_valid,
  input  logic [RET_W*PREG_IDX_W-1:0]   ret_new_idx,
  input  logic [RET_W*PREG_IDX_W-1:0]   ret_old_idx,
  input  logic                          mispredict,
  output logic [PREG_IDX_W:0]           free_count
`ifdef PREG_FREE_LIST_CHECK_EN
  ,
  output logic                          double_free_err
`endif
);

  localparam logic [NUM_PREGS-1:0] RESET_FREE = {NUM_PREGS{1'b1}} << NUM_AREGS;
  localparam logic [PREG_IDX_W:0]  RESET_CNT  = (PREG_IDX_W+1)'(NUM_PREGS - NUM_AREGS);

  logic [NUM_PREGS-1:0]  spec_free_q, spec_free_d;
  logic [NUM_PREGS-1:0]  arch_free_q, arch_free_d;
  logic [PREG_IDX_W:0]   free_count_q, free_count_d;
  logic [NUM_PREGS-1:0]  granted_bits, rel_bits, new_bits, avail;
  logic                  chain_ok, found;
  logic [PREG_IDX_W-1:0] pick;

  function automatic logic [PREG_IDX_W:0] popcount(input logic [NUM_PREGS-1:0] v);
    logic [PREG_IDX_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_PREGS; i++) c = c + {{PREG_IDX_W{1'b0}}, v[i]};
    return c;
  endfunction

  // Each requesting slot takes the next lowest free preg; a failed slot blocks all later slots.
  always_comb begin
    avail        = spec_free_q;
    chain_ok     = 1'b1;
    found        = 1'b0;
    pick         = '0;
    alloc_gnt    = '0;
    alloc_idx    = '0;
    granted_bits = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (alloc_req[k] && chain_ok && !mispredict && !reset) begin
        found = 1'b0;
        pick  = '0;
        for (int p = NUM_PREGS - 1; p >= 0; p--) begin
          if (avail[p]) begin
            found = 1'b1;
            pick  = PREG_IDX_W'(p);
          end
        end
        if (found) begin
          alloc_gnt[k]                             = 1'b1;
          alloc_idx[k*PREG_IDX_W +: PREG_IDX_W]    = pick;
          avail[pick]                              = 1'b0;
          granted_bits[pick]                       = 1'b1;
        end else begin
          chain_ok = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rel_bits = '0;
    new_bits = '0;
    for (int r = 0; r < RET_W; r++) begin
      if (ret_valid[r]) begin
        rel_bits[ret_old_idx[r*PREG_IDX_W +: PREG_IDX_W]] = 1'b1;
        new_bits[ret_new_idx[r*PREG_IDX_W +: PREG_IDX_W]] = 1'b1;
      end
    end
    // Clear before set so new==old in one slot leaves the preg free.
    arch_free_d  = (arch_free_q & ~new_bits) | rel_bits;
    spec_free_d  = mispredict ? arch_free_d : ((spec_free_q & ~granted_bits) | rel_bits);
    free_count_d = popcount(spec_free_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_free_q  <= RESET_FREE;
      arch_free_q  <= RESET_FREE;
      free_count_q <= RESET_CNT;
    end else begin
      spec_free_q  <= spec_free_d;
      arch_free_q  <= arch_free_d;
      free_count_q <= free_count_d;
    end
  end

  assign free_count = free_count_q;

`ifdef PREG_FREE_LIST_CHECK_EN
  logic double_free_err_q, double_free_err_d;

  // Sticky: releasing an already-free preg, or the same preg from two slots at once.
  always_comb begin
    double_free_err_d = double_free_err_q;
    for (int r = 0; r < RET_W; r++) begin
      if (ret_valid[r] && arch_free_q[ret_old_idx[r*PREG_IDX_W +: PREG_IDX_W]])
        double_free_err_d = 1'b1;
      for (int s = r + 1; s < RET_W; s++) begin
        if (ret_valid[r] && ret_valid[s] &&
            (ret_old_idx[r*PREG_IDX_W +: PREG_IDX_W] == ret_old_idx[s*PREG_IDX_W +: PREG_IDX_W]))
          double_free_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) double_free_err_q <= 1'b0;
    else       double_free_err_q <= double_free_err_d;
  end

  assign double_free_err = double_free_err_q;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Scoreboard bench for preg_free_list: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_preg_free_list;

  logic        clock;
  logic        reset;
  logic [1:0]  alloc_req;
  logic [1:0]  alloc_gnt;
  logic [11:0] alloc_idx;
  logic [1:0]  ret_valid;
  logic [11:0] ret_new_idx;
  logic [11:0] ret_old_idx;
  logic        mispredict;
  logic [6:0]  free_count;
`ifdef PREG_FREE_LIST_CHECK_EN
  logic        double_free_err;
`endif

  preg_free_list dut (
    .clock      (clock),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_idx  (alloc_idx),
    .ret_valid  (ret_valid),
    .ret_new_idx(ret_new_idx),
    .ret_old_idx(ret_old_idx),
    .mispredict (mispredict),
    .free_count (free_count)
`ifdef PREG_FREE_LIST_CHECK_EN
    ,
    .double_free_err(double_free_err)
`endif
  );

  typedef struct {
    string      name;
    logic [1:0] gnt;
    int         i0;
    int         i1;
    int         fc;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, ".gnt"}, int'(alloc_gnt), int'(e.gnt));
      chk({e.name, ".idx0"}, int'(alloc_idx[5:0]), e.i0);
      chk({e.name, ".idx1"}, int'(alloc_idx[11:6]), e.i1);
      if (e.fc >= 0) chk({e.name, ".free_count"}, int'(free_count), e.fc);
`ifdef PREG_FREE_LIST_CHECK_EN
      chk({e.name, ".err"}, int'(double_free_err), int'(e.err));
`endif
    end
  end

  task automatic step(input string nm, input logic rst_v, input logic [1:0] req,
                      input logic [1:0] rv, input int n0, input int o0, input int n1, input int o1,
                      input logic mp, input logic [1:0] eg, input int ei0, input int ei1, input int efc);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst_v;
    alloc_req   = req;
    ret_valid   = rv;
    ret_new_idx = {6'(n1), 6'(n0)};
    ret_old_idx = {6'(o1), 6'(o0)};
    mispredict  = mp;
    e.name = nm; e.gnt = eg; e.i0 = ei0; e.i1 = ei1; e.fc = efc; e.err = exp_err;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; alloc_req = '0; ret_valid = '0; ret_new_idx = '0; ret_old_idx = '0; mispredict = 1'b0;
    #2 reset = 1'b1;

    // reset state and slot skip
    step("rst",      1, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32);
    step("skip",     0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b10, 0, 32, 32);
    step("rst_mid",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32);
    // first dual allocation
    step("alloc0",   0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b11, 32, 33, 32);
    step("idle0",    0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 30);
    // drain down to a single free preg
    for (int i = 0; i < 14; i++)
      step("drain",  0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b11, 34 + 2*i, 35 + 2*i, 30 - 2*i);
    step("drain62",  0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b01, 62, 0, 2);
    step("last1",    0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b01, 63, 0, 1);
    step("empty",    0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    // release is not allocatable in the same cycle
    step("rel_same", 0, 2'b01, 2'b01, 40, 5, 0, 0, 0, 2'b00, 0, 0, 0);
    step("rel_next", 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 1);
    step("rel_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    // mispredict restore
    step("mp_rst",   1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32);
    step("mp_a0",    0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b11, 32, 33, 32);
    step("mp_a1",    0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b11, 34, 35, 30);
    step("mp_ret",   0, 2'b00, 2'b01, 32, 3, 0, 0, 0, 2'b00, 0, 0, 28);
    step("mp_sq",    0, 2'b11, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 29);
    step("mp_after", 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b11, 3, 33, 32);
    step("mp_idle",  0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 30);
`ifdef PREG_FREE_LIST_CHECK_EN
    step("df_rst",   1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32);
    step("df_ret",   0, 2'b00, 2'b01, 10, 40, 0, 0, 0, 2'b00, 0, 0, 32);
    exp_err = 1'b1;
    step("df_set",   0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32);
    step("df_hold",  0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32);
    exp_err = 1'b0;
    step("df_clr",   1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32);
`endif
    repeat (2) @(negedge clock);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Physical-register free list and allocator for the R10K-style rename stage.
- Holds a speculative free bitmap and an architectural free bitmap over all physical registers.
- Grants up to ALLOC_W lowest-index free registers per cycle using priority selection.
- Returns registers to the free pool at retire, and restores the speculative bitmap from the architectural bitmap on branch mispredict.

Parameters:
- NUM_PREGS, `PHYS_REG_SZ_R10K (64): number of physical registers.
- PREG_IDX_W, `PHYS_REG_ID_BITS (6): physical register index width.
- NUM_AREGS, 32: architectural registers. Pregs 0..NUM_AREGS-1 are mapped at reset.
- ALLOC_W, 2: allocation ports per cycle.
- RET_W, 2: retire ports per cycle.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- alloc_req  in  ALLOC_W  per-slot request from rename. Slot 0 is oldest.
- alloc_gnt  out  ALLOC_W  per-slot grant (combinational).
- alloc_idx  out  ALLOC_W*PREG_IDX_W  granted preg index per slot. Slot k occupies bits [k*PREG_IDX_W +: PREG_IDX_W].
- ret_valid  in  RET_W  retire slot valid.
- ret_new_idx  in  RET_W*PREG_IDX_W  preg (T) becoming architectural.
- ret_old_idx  in  RET_W*PREG_IDX_W  preg (Told) being released.
- mispredict  in  1  squash; restore the speculative bitmap.
- free_count  out  PREG_IDX_W+1  registered popcount of the speculative bitmap.
- double_free_err  out  1  present only with PREG_FREE_LIST_CHECK_EN.

Behaviour:
- State:
  - spec_free[NUM_PREGS] and arch_free[NUM_PREGS]. Bit = 1 means the preg is free.
  - free_count register.
- Reset (async):
  - spec_free = arch_free = bits NUM_AREGS..NUM_PREGS-1 set, bits 0..NUM_AREGS-1 clear.
  - free_count = NUM_PREGS-NUM_AREGS (32).
  - alloc_gnt = 0, alloc_idx = 0, double_free_err = 0.
  - Reset mid-operation discards all in-flight grants and retires.
- Allocation (combinational from registered spec_free):
  - Requested slots are served in ascending slot order.
  - The j-th requesting slot receives the j-th lowest set bit of spec_free.
  - Slot k is granted only if slot k requests, every lower requesting slot is granted, and enough free pregs exist.
  - There are no grant holes: if 1 preg is free and slots 0,1 request, only slot 0 is granted.
  - If slot 0 is idle and slot 1 requests, slot 1 gets the lowest free preg.
  - Non-granted slots drive alloc_idx = 0.
  - When mispredict = 1, all grants are forced to 0.
- Next-state, normal cycle:
  - spec_free' = spec_free & ~granted_bits | released_bits, where released_bits = ret_old_idx of valid retires.
  - Registers released this cycle are allocatable next cycle, never in the same cycle.
  - arch_free' = arch_free & ~ret_new bits | ret_old bits.
  - Clears are applied before sets; retire slots are independent.
- Mispredict cycle:
  - spec_free' = arch_free' (arch_free including this cycle's retire updates).
  - Granted bits are ignored.
- free_count' = popcount(spec_free'). It is registered, so it lags by one cycle.
  - It never exceeds NUM_PREGS; with legal inputs it never exceeds NUM_PREGS-NUM_AREGS.
- Retire with ret_new_idx == ret_old_idx in one slot: net effect is that the preg ends free. Legal but unexpected.
- Index 0 may be allocated after being released; it is not special.

Optional Feature:
- Macro: PREG_FREE_LIST_CHECK_EN.
- Defined:
  - A valid retire whose ret_old_idx is already set in arch_free, or two retire slots releasing the same preg in one cycle, sets double_free_err.
  - double_free_err is sticky until reset.
  - The bitmap update still proceeds (OR semantics).
- Undefined:
  - The port and check logic are absent.
  - Double frees silently OR into the bitmaps.

Test Plan:
1. After reset: free_count = 32. alloc_req=2'b11 → alloc_gnt=11, idx {slot0=32, slot1=33}. Next cycle free_count = 30.
2. Drain: allocate repeatedly until 1 free (preg 63). alloc_req=11 → gnt=01, slot0 idx=63. Next cycle alloc_req=11 → gnt=00, free_count = 0.
3. Same-cycle release: free_count = 0. Retire ret_old=5 while alloc_req=01 → gnt=0 this cycle. Next cycle gnt=01, idx=5.
4. Mispredict: allocate 32..35, retire new=32/old=3. Assert mispredict with alloc_req=11 → gnt=00. Next cycle spec_free bits {3, 33..63} set and free_count = 32.
5. Slot skip: alloc_req=2'b10 after reset → gnt=10, slot1 idx=32, slot0 idx=0.
6. CHECK_EN: retire ret_old=40 while 40 is already free → double_free_err=1 next cycle. It stays 1 until reset asserts, and clears asynchronously on reset.
